fir_requant_fifo: RTL and testbench
===================================

Name: fir_requant_fifo

Overview:
- Downstream stage of the FIR filter core. Consumes the FIR core's 34-bit AXI-Stream output.
- Rounds and saturates each sample to 16-bit signed, then buffers it in a small FIFO.
- Presents the buffered samples on a back-pressurable AXI-Stream master for the DAC/packetiser side.
- Needed because the FIR master port has no tready: every valid FIR beat must be taken. Loss is flagged, never silent.

Parameters:
- IN_W, 34, input sample width (signed two's complement)
- OUT_W, 16, output sample width (signed)
- SHIFT, 17, LSBs dropped by rounding; must satisfy 1 <= SHIFT < IN_W
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16)

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- s_axis_data_tvalid  in  1  FIR output valid; no tready, beat is always consumed
- s_axis_data_tdata  in  IN_W  FIR output sample
- m_axis_data_tvalid  out  1  output sample available
- m_axis_data_tready  in  1  downstream accept
- m_axis_data_tdata  out  OUT_W  requantised sample
- fill_level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH
- sat_flag  out  1  sticky: a sample saturated
- ovf_flag  out  1  sticky: a sample was dropped because the FIFO was full
- flag_clr  in  1  synchronous pulse; clears sat_flag and ovf_flag

Behaviour:
- Reset (aresetn low, asynchronous):
  - FIFO emptied; pointers and fill_level set to 0.
  - m_axis_data_tvalid=0, m_axis_data_tdata=0, sat_flag=0, ovf_flag=0.
  - Pipeline valid bits cleared.
  - Reset mid-stream discards all in-flight and buffered samples. No partial output after release.
- Stage 1 (registered): on s_axis_data_tvalid, compute sum = sign-extend(tdata, IN_W+1) + 2**(SHIFT-1). This is round-half-up. Register sum and v1.
- Stage 2 (combinational into FIFO write):
  - q = sum >>> SHIFT (arithmetic shift).
  - If q > 2**(OUT_W-1)-1, write 0x7FFF.
  - If q < -2**(OUT_W-1), write 0x8000.
  - Otherwise write q[OUT_W-1:0].
  - Any clamp sets sat_flag on the write cycle.
- Write enable: wr = v1 && (!full || rd).
  - If v1 && full && !rd, the sample is dropped and ovf_flag is set. FIFO contents are unchanged.
- Read: rd = m_axis_data_tvalid && m_axis_data_tready.
- FIFO is first-word-fall-through: m_axis_data_tvalid = !empty, and m_axis_data_tdata = entry at the read pointer.
- Latency: input beat sampled at edge E0 appears at the output (tvalid=1) after edge E1, i.e. 2 cycles, when the FIFO was empty.
- Throughput: one sample per clock in and out. Back-to-back input with tready held high never fills the FIFO beyond 1.
- Simultaneous read and write:
  - fill_level unchanged.
  - When full, the read frees the slot and the write is accepted, with no overflow.
  - When empty, no read is possible (tvalid=0). The write lands and tvalid rises next cycle.
- AXI rules:
  - m_axis_data_tdata is stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Full/empty are derived from fill_level.
- Flags:
  - flag_clr has priority over a set in the same cycle, so the flag reads 0 afterwards.
  - A set on any later cycle re-asserts the flag.

Decomposition:
- Package fir_pkg holds:
  - FIR_OUT_W=34, SAMPLE_W=16 and the default SHIFT.
  - A sat_round function (rounding, shift and clamp) shared with the testbench reference model.
- One sub-module is natural: sync_fifo_fwft (parameters WIDTH, DEPTH_LOG2; ports wr, din, rd, dout, empty, full, level). The top holds the two arithmetic stages and the flags.

Test Plan:
- Rounding, tready=1: inputs 65536, 65535, -65536, -65537 -> outputs 0x0001, 0x0000, 0x0000, 0xFFFF, each 2 cycles after input; sat_flag stays 0.
- Saturation: input 2**33-1 -> 0x7FFF; input -2**33 -> 0x8000; sat_flag=1. Pulse flag_clr -> sat_flag=0.
- Back-pressure/fill: tready=0, 16 consecutive valid inputs 0..15 (each ×2**17) -> fill_level=16, ovf_flag=0. Release tready -> outputs 0..15 in order, tdata stable while stalled.
- Overflow: with FIFO full and tready=0, 3 more inputs -> ovf_flag=1, fill_level stays 16, the 3 samples are absent from the output. Full with rd and wr in the same cycle -> no overflow, level stays 16.
- Wrap-around: 40 samples streamed with random tready (≈50%) -> output sequence equals the reference model, no loss while fill_level < 16.
- Reset mid-operation: aresetn low asynchronously with 7 entries buffered -> tvalid=0 and fill_level=0 immediately. After release, the first new input appears 2 cycles later; no stale data.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants and arithmetic helpers for the FIR output requantiser.
//   FIR_OUT_W : width of the FIR core output sample (signed)
//   SAMPLE_W  : width of the requantised output sample (signed)
//   DEF_SHIFT : default number of LSBs dropped by rounding
//   sat_round : round-half-up, arithmetic shift and clamp of one FIR sample
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_OUT_W = 34;
  localparam int SAMPLE_W  = 16;
  localparam int DEF_SHIFT = 17;

  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic                sat;
  } sat_res_t;

  // Rounds x by adding half an output LSB, drops 'shift' LSBs and clamps the
  // result into the signed SAMPLE_W range. 'sat' reports whether a clamp hit.
  function automatic sat_res_t sat_round(input logic [FIR_OUT_W-1:0] x,
                                         input int unsigned          shift);
    logic signed [FIR_OUT_W:0] sum;
    logic signed [FIR_OUT_W:0] q;
    logic signed [FIR_OUT_W:0] max_v;
    logic signed [FIR_OUT_W:0] min_v;
    sat_res_t                  res;
    max_v    = {{(FIR_OUT_W-SAMPLE_W+2){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    min_v    = {{(FIR_OUT_W-SAMPLE_W+2){1'b1}}, {(SAMPLE_W-1){1'b0}}};
    sum      = $signed({x[FIR_OUT_W-1], x}) + $signed((FIR_OUT_W+1)'(1) << (shift - 1));
    q        = sum >>> shift;
    res.sat  = 1'b1;
    if (q > max_v) begin
      res.data = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (q < min_v) begin
      res.data = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      res.data = q[SAMPLE_W-1:0];
      res.sat  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_requant_fifo_if.sv
// -----------------------------------------------------------------------------
// fir_requant_fifo_if
// Minimal AXI-Stream bundle used on both sides of the requantiser.
//   tvalid : beat valid (master -> slave)
//   tready : beat accept (slave -> master)
//   tdata  : sample, W bits (master -> slave)
// -----------------------------------------------------------------------------
interface fir_requant_fifo_if #(
  parameter int W = 16
) ();

  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport master (output tvalid, output tdata, input  tready);
  modport slave  (input  tvalid, input  tdata, output tready);

endinterface

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO, 2**DEPTH_LOG2 entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr, din    : push din (ignored when full and not reading)
//   rd, dout   : pop; dout shows the head entry, or 0 when empty
//   empty/full : derived from level
//   level      : occupancy, 0..2**DEPTH_LOG2
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_wr;
  logic                  w_rd;

  assign empty = (r_level == '0);
  assign full  = (r_level == FULL_LVL);
  assign level = r_level;

  // A read frees a slot in the same cycle, so a write into a full FIFO is
  // legal only alongside a read.
  assign w_rd = rd && !empty;
  assign w_wr = wr && (!full || w_rd);

  // Empty FIFO presents zero so nothing stale leaks after a reset.
  assign dout = empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally through their DEPTH_LOG2-bit width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fir_requant_fifo.sv
// -----------------------------------------------------------------------------
// fir_requant_fifo
// Rounds/saturates each FIR output sample to OUT_W bits and buffers it in a
// FWFT FIFO feeding a back-pressurable AXI-Stream master. The FIR side has no
// back-pressure, so a sample arriving at a full FIFO is dropped and flagged.
//   aclk, aresetn : clock, asynchronous active-low reset
//   s_axis_data   : FIR input stream (tready tied high, every beat consumed)
//   m_axis_data   : requantised output stream
//   fill_level    : FIFO occupancy, 0..2**DEPTH_LOG2
//   sat_flag      : sticky, a written sample was clamped
//   ovf_flag      : sticky, a sample was dropped on a full FIFO
//   flag_clr      : synchronous clear of both flags, wins over a set
// -----------------------------------------------------------------------------
module fir_requant_fifo
  import fir_pkg::*;
#(
  parameter int IN_W       = FIR_OUT_W,
  parameter int OUT_W      = SAMPLE_W,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  fir_requant_fifo_if.slave      s_axis_data,
  fir_requant_fifo_if.master     m_axis_data,
  output logic [DEPTH_LOG2:0]    fill_level,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  input  logic                   flag_clr
);

  localparam logic        [IN_W:0] ROUND = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [IN_W-1:0]        w_in_data;
  logic [IN_W:0]          r_sum;
  logic                   r_v1;
  logic signed [IN_W:0]   w_q;
  logic                   w_hi;
  logic                   w_lo;
  logic [OUT_W-1:0]       w_din;
  logic [OUT_W-1:0]       w_dout;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_rd;
  logic                   w_wr;
  logic                   r_sat_flag;
  logic                   r_ovf_flag;

  assign s_axis_data.tready = 1'b1;
  assign w_in_data          = s_axis_data.tdata;

  // Stage 1: sign-extend by one bit so adding half an LSB cannot overflow.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_v1  <= 1'b0;
      r_sum <= '0;
    end else begin
      r_v1 <= s_axis_data.tvalid;
      if (s_axis_data.tvalid) r_sum <= {w_in_data[IN_W-1], w_in_data} + ROUND;
    end
  end

  // Stage 2: arithmetic shift then clamp into the signed OUT_W range.
  assign w_q  = $signed(r_sum) >>> SHIFT;
  assign w_hi = (w_q > MAX_V);
  assign w_lo = (w_q < MIN_V);

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_din = w_q[OUT_W-1:0];
    if (w_hi)      w_din = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_lo) w_din = {1'b1, {(OUT_W-1){1'b0}}};
  end

  assign w_rd = !w_empty && m_axis_data.tready;
  assign w_wr = r_v1 && (!w_full || w_rd);

  sync_fifo_fwft #(
    .WIDTH      (OUT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .wr    (w_wr),
    .din   (w_din),
    .rd    (w_rd),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .level (fill_level)
  );

  assign m_axis_data.tvalid = !w_empty;
  assign m_axis_data.tdata  = w_dout;

  // Sticky flags; a clear in the same cycle as a set wins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sat_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else if (flag_clr) begin
      r_sat_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else begin
      if (w_wr && (w_hi || w_lo)) r_sat_flag <= 1'b1;
      if (r_v1 && !w_wr)          r_ovf_flag <= 1'b1;
    end
  end

  assign sat_flag = r_sat_flag;
  assign ovf_flag = r_ovf_flag;

endmodule

// File: tb/tb_fir_requant_fifo.sv
// -----------------------------------------------------------------------------
// tb_fir_requant_fifo
// Directed and randomized stimulus for fir_requant_fifo, checked every cycle
// against a queue-based transaction model plus explicit spot checks.
// -----------------------------------------------------------------------------
module tb_fir_requant_fifo;
  import fir_pkg::*;

  localparam int IN_W  = 34;
  localparam int OUT_W = 16;
  localparam int SHIFT = 17;
  localparam int DEPTH = 16;

  logic        aclk;
  logic        aresetn;
  logic [4:0]  fill_level;
  logic        sat_flag;
  logic        ovf_flag;
  logic        flag_clr;

  fir_requant_fifo_if #(.W(IN_W))  s_if ();
  fir_requant_fifo_if #(.W(OUT_W)) m_if ();

  fir_requant_fifo dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis_data (s_if),
    .m_axis_data (m_if),
    .fill_level  (fill_level),
    .sat_flag    (sat_flag),
    .ovf_flag    (ovf_flag),
    .flag_clr    (flag_clr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks;
  int errors;

  // Reference model state: the sample in flight and the buffered samples.
  bit          m_pend_v;
  logic [33:0] m_pend_d;
  logic [15:0] m_q[$];
  bit          m_sat;
  bit          m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clamp.
  function automatic void model_q(input logic [33:0] d, output logic [15:0] q16, output bit clamped);
    longint x;
    longint q;
    x = longint'($signed(d));
    q = (x + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    clamped = 1'b1;
    if (q > 32767)       q16 = 16'h7FFF;
    else if (q < -32768) q16 = 16'h8000;
    else begin
      q16     = q[15:0];
      clamped = 1'b0;
    end
  endfunction

  task automatic model_reset();
    m_pend_v = 1'b0;
    m_pend_d = '0;
    m_q.delete();
    m_sat = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [33:0] d, input bit rdy, input bit clr);
    bit          rd;
    bit          wr;
    bit          clamped;
    logic [15:0] q16;
    rd = (m_q.size() > 0) && rdy;
    wr = m_pend_v && ((m_q.size() < DEPTH) || rd);
    model_q(m_pend_d, q16, clamped);
    if (rd) void'(m_q.pop_front());
    if (wr) m_q.push_back(q16);
    if (clr) begin
      m_sat = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (wr && clamped)   m_sat = 1'b1;
      if (m_pend_v && !wr) m_ovf = 1'b1;
    end
    m_pend_v = v;
    m_pend_d = d;
  endtask

  task automatic compare_all();
    check("tvalid", 64'(m_if.tvalid), 64'(m_q.size() > 0));
    check("tdata",  64'(m_if.tdata),  64'((m_q.size() > 0) ? m_q[0] : 16'h0000));
    check("fill",   64'(fill_level),  64'(m_q.size()));
    check("sat",    64'(sat_flag),    64'(m_sat));
    check("ovf",    64'(ovf_flag),    64'(m_ovf));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare
  // at the next falling edge.
  task automatic step(input bit v, input logic [33:0] d, input bit rdy, input bit clr);
    s_if.tvalid  = v;
    s_if.tdata   = d;
    m_if.tready  = rdy;
    flag_clr     = clr;
    @(posedge aclk);
    model_edge(v, d, rdy, clr);
    @(negedge aclk);
    compare_all();
  endtask

  initial begin
    longint      rnd_in  [4];
    logic [15:0] rnd_exp [4];
    logic [33:0] d;
    logic [1:0]  hi2;
    sat_res_t    pr;
    logic [15:0] mq16;
    bit          mcl;
    int          sent;
    int          cyc;

    checks = 0;
    errors = 0;
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    flag_clr    = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge aclk);
    check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_tdata",  64'(m_if.tdata),  64'd0);
    check("rst_fill",   64'(fill_level),  64'd0);
    check("rst_sat",    64'(sat_flag),    64'd0);
    check("rst_ovf",    64'(ovf_flag),    64'd0);
    aresetn = 1'b1;

    // Package helper against the integer model
    rnd_in = '{65536, 65535, -65536, -65537};
    for (int i = 0; i < 4; i++) begin
      d  = 34'(rnd_in[i]);
      pr = sat_round(d, SHIFT);
      model_q(d, mq16, mcl);
      check("pkg_sat_round", 64'(pr.data), 64'(mq16));
    end

    // Rounding, back-to-back with tready high: 2-cycle latency, level <= 1
    rnd_exp = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    for (int i = 0; i < 6; i++) begin
      step(i < 4, (i < 4) ? 34'(rnd_in[i]) : 34'd0, 1'b1, 1'b0);
      if (i == 0) check("lat_first_tvalid", 64'(m_if.tvalid), 64'd0);
      if (i >= 1 && i <= 4) begin
        check("round_tvalid", 64'(m_if.tvalid), 64'd1);
        check("round_tdata",  64'(m_if.tdata),  64'(rnd_exp[i-1]));
        check("round_fill",   64'(fill_level),  64'd1);
      end
    end
    check("round_sat_clear", 64'(sat_flag), 64'd0);

    // Saturation and flag clear
    step(1'b1, 34'h1_FFFF_FFFF, 1'b1, 1'b0);
    step(1'b1, 34'h2_0000_0000, 1'b1, 1'b0);
    check("sat_pos", 64'(m_if.tdata), 64'h7FFF);
    step(1'b0, '0, 1'b1, 1'b0);
    check("sat_neg", 64'(m_if.tdata), 64'h8000);
    check("sat_set", 64'(sat_flag),   64'd1);
    step(1'b0, '0, 1'b1, 1'b1);
    check("sat_cleared", 64'(sat_flag), 64'd0);

    // Fill to full with tready low
    for (int i = 0; i < 16; i++) step(1'b1, 34'(i) << SHIFT, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("full_fill", 64'(fill_level), 64'd16);
    check("full_ovf",  64'(ovf_flag),   64'd0);
    check("full_head", 64'(m_if.tdata), 64'd0);

    // Overflow: three more samples are dropped
    for (int i = 0; i < 3; i++) step(1'b1, 34'(100 + i) << SHIFT, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("ovf_set",  64'(ovf_flag),   64'd1);
    check("ovf_fill", 64'(fill_level), 64'd16);
    check("ovf_head_stable", 64'(m_if.tdata), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovf_cleared", 64'(ovf_flag), 64'd0);

    // Full with read and write on the same edge: no loss, level holds
    step(1'b1, 34'(16) << SHIFT, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("rw_full_fill", 64'(fill_level), 64'd16);
    check("rw_full_ovf",  64'(ovf_flag),   64'd0);
    check("rw_full_head", 64'(m_if.tdata), 64'd1);

    // Drain: 1..16 in order (model checks every beat)
    for (int i = 0; i < 16; i++) begin
      check("drain_order", 64'(m_if.tdata), 64'(i + 1));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_empty", 64'(fill_level), 64'd0);

    // Randomized stream with random back-pressure
    sent = 0;
    cyc  = 0;
    while (sent < 40 && cyc < 400) begin
      bit v;
      v   = ($urandom_range(0, 3) != 0);
      hi2 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) d = 34'($signed(32'($urandom())) >>> 2);
      else                           d = {hi2, 32'($urandom())};
      step(v, d, ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
      if (v) sent++;
      cyc++;
    end
    check("rand_sent_all", 64'(sent), 64'd40);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("rand_drained", 64'(fill_level), 64'd0);

    // Asynchronous reset mid-stream: 7 buffered plus one in flight
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 34'(i + 20) << SHIFT, 1'b0, 1'b0);
    check("pre_rst_fill", 64'(fill_level), 64'd7);
    #2 aresetn = 1'b0;
    #1;
    check("async_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    check("async_rst_fill",   64'(fill_level),  64'd0);
    check("async_rst_tdata",  64'(m_if.tdata),  64'd0);
    model_reset();
    s_if.tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    check("no_stale", 64'(m_if.tvalid), 64'd0);
    step(1'b1, 34'(5) << SHIFT, 1'b1, 1'b0);
    check("post_rst_lat0", 64'(m_if.tvalid), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_tvalid", 64'(m_if.tvalid), 64'd1);
    check("post_rst_tdata",  64'(m_if.tdata),  64'd5);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
